vdc_regfile_gen: RTL and testbench
==================================

Name: vdc_regfile_gen

Overview:
- Parametrised CPU-side register file for the VDC family, replacing the hard-coded register case logic in the chip top level.
- Implements the indirect address/data port pair ($D600/$D601), a per-register write mask, and unused-bit readback as 1s.
- Adds version-gated extension registers, light-pen latching, a CPU-to-RAM-interface write queue with handshake, and an optional auto-increment of the register select.
- Sits between the bus decode and the clock generator, video and RAM interface blocks, and exports all stored registers as a flat vector.

Parameters:
- NUM_REGS, 38, number of implemented registers (R0..R[NUM_REGS-1]).
- SEL_WIDTH, 6, width of the register select latch.
- WMASK, {NUM_REGS{8'hFF}}, flat NUM_REGS*8 vector; 1 = bit is stored; 0 = bit reads as 1.
- EXT_MASK, 38'h0003_C00C_0000, bit i = 1 routes writes of Ri to the RAM-interface queue (R18, R19, R30..R33) instead of storing them.
- VER_FIRST, 37, first register index that exists only when version[1] = 1.
- QDEPTH, 2, write-queue depth (power of 2, at least 2).
- AUTO_INC, 0, 1 = the select increments after each data-port access.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- version, in, 2, chip version (0 = 8563R7A, 1 = 8563R9, 2 = 8568).
- enable_bus, in, 1, one-cycle bus access strobe.
- cs, in, 1, chip select.
- rs, in, 1, 0 = address/status port, 1 = data port.
- we, in, 1, write enable.
- db_in, in, 8, CPU write data.
- db_out, out, 8, registered read data.
- vblank, in, 1, status bit 5.
- ram_busy, in, 1, RAM interface busy.
- lp_strobe, in, 1, light-pen trigger pulse.
- lp_v, in, 8, light-pen vertical position.
- lp_h, in, 8, light-pen horizontal position.
- ext_rdata, in, 8, read value of the currently selected external register.
- ext_wr_valid, out, 1, queue head valid.
- ext_wr_addr, out, SEL_WIDTH, queue head register index.
- ext_wr_data, out, 8, queue head data.
- ext_wr_ready, in, 1, consumer accepts the queue head.
- reg_sel, out, SEL_WIDTH, current register select.
- regs_flat, out, NUM_REGS*8, stored register values; Ri occupies bits [8i+7:8i], masked bits read as 0.

Behaviour:
- Access happens only on a cycle with cs & enable_bus; all other cycles hold state and db_out.
- Reset values: reg_sel = 0, all registers = 0, db_out = 8'hFF, lp_status = 0, queue empty, ext_wr_valid = 0.
- Register exists when index < NUM_REGS and (index < VER_FIRST or version[1] = 1).
- Address-port write (rs = 0, we = 1): reg_sel <= db_in[SEL_WIDTH-1:0].
- Data-port write (rs = 1, we = 1) to an existing non-EXT register: Ri <= (Ri & ~WMASK_i) | (db_in & WMASK_i).
- Data-port write to an existing EXT register: the entry {reg_sel, db_in} is pushed to the queue.
- Data-port write to a non-existent register: ignored.
- Status read (rs = 0, we = 0): db_out <= {~busy, lp_status, vblank, 3'b000, version}, where busy = ram_busy | queue not empty. lp_status is cleared on the same cycle.
- Data read, non-EXT register: db_out <= Ri | ~WMASK_i.
- Data read, EXT register: db_out <= ext_rdata.
- Data read, non-existent register: db_out <= 8'hFF.
- Read latency: db_out is valid the cycle after the strobe.
- Light pen: when lp_strobe = 1 and lp_status = 0, latch R16 <= lp_v, R17 <= lp_h and set lp_status. Further strobes are ignored until a status read clears lp_status.
- Strobe and status read on the same cycle: db_out shows the old lp_status, then lp_status ends up set and R16/R17 are loaded.
- Queue: FIFO with a QDEPTH-entry ring and a count register. Pop occurs when ext_wr_valid & ext_wr_ready.
- Queue full: a push is dropped, and the dropped write is reported as busy by status bit 7 = 0.
- Queue full with a simultaneous push and pop: both take effect and count is unchanged.
- Queue head outputs are held stable while ext_wr_valid = 1 and ext_wr_ready = 0.
- AUTO_INC = 1: after any data-port access, reg_sel <= (reg_sel == NUM_REGS-1) ? 0 : reg_sel + 1. The increment uses the pre-access reg_sel.
- AUTO_INC = 0: reg_sel changes only through address-port writes.
- Reset asserted mid-transfer: the queue is flushed and ext_wr_valid drops in the next cycle, with no partial entry.

Test Plan:
- Reset, then status read with version = 2, vblank = 1, ram_busy = 0 -> db_out = 8'hA2.
- Select R5 with WMASK_5 = 8'h1F, write 8'hFF -> regs_flat R5 = 8'h1F, and readback = 8'hFF.
- version = 0, select R37, write 8'hC0 then read -> R37 stays 0 and db_out = 8'hFF. version = 2, same sequence -> stored value 8'hC0 is read back.
- Hold ext_wr_ready = 0 and write R31 three times with 8'h11, 8'h22, 8'h33 -> 8'h11 and 8'h22 are queued, 8'h33 is dropped, status bit 7 = 0. Release ready -> two pops in order and status bit 7 = 1.
- lp_strobe with lp_v = 8'h40, lp_h = 8'h21, then a second strobe with other values -> R16 = 8'h40, R17 = 8'h21 and status bit 6 = 1. Status read -> bit 6 returns to 0.
- AUTO_INC = 1, select R36 (NUM_REGS = 38), two data writes -> R36 and R37 are written and reg_sel wraps to 0.

Source files
------------

// File: rtl/vdc_regfile_gen_if.sv
// CPU bus and RAM-interface write-queue signals for the VDC register file.
// master: bus decode / RAM interface side (drives strobes, write data,
//         ext_rdata, ext_wr_ready).
// slave:  register file side (drives db_out and the queue head).
interface vdc_regfile_gen_if #(
  parameter int unsigned SEL_WIDTH = 6
);
  logic                 enable_bus;
  logic                 cs;
  logic                 rs;
  logic                 we;
  logic [7:0]           db_in;
  logic [7:0]           db_out;
  logic [7:0]           ext_rdata;
  logic                 ext_wr_valid;
  logic [SEL_WIDTH-1:0] ext_wr_addr;
  logic [7:0]           ext_wr_data;
  logic                 ext_wr_ready;

  modport master (
    output enable_bus, cs, rs, we, db_in, ext_rdata, ext_wr_ready,
    input  db_out, ext_wr_valid, ext_wr_addr, ext_wr_data
  );

  modport slave (
    input  enable_bus, cs, rs, we, db_in, ext_rdata, ext_wr_ready,
    output db_out, ext_wr_valid, ext_wr_addr, ext_wr_data
  );
endinterface

// File: rtl/vdc_regfile_gen.sv
// Parametrised CPU-side register file for the VDC family.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   version           chip version (bit 1 enables the late extension registers)
//   bus               CPU address/data port plus RAM-interface write queue
//   vblank, ram_busy  status inputs
//   lp_strobe/v/h     light-pen trigger and position
//   reg_sel           current register select
//   regs_flat         all stored registers, Ri at [8i+7:8i]
module vdc_regfile_gen #(
  parameter int unsigned           NUM_REGS  = 38,
  parameter int unsigned           SEL_WIDTH = 6,
  parameter logic [NUM_REGS*8-1:0] WMASK     = {NUM_REGS{8'hFF}},
  parameter logic [NUM_REGS-1:0]   EXT_MASK  = NUM_REGS'(38'h0003_C00C_0000),
  parameter int unsigned           VER_FIRST = 37,
  parameter int unsigned           QDEPTH    = 2,
  parameter bit                    AUTO_INC  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              version,
  vdc_regfile_gen_if.slave        bus,
  input  logic                    vblank,
  input  logic                    ram_busy,
  input  logic                    lp_strobe,
  input  logic [7:0]              lp_v,
  input  logic [7:0]              lp_h,
  output logic [SEL_WIDTH-1:0]    reg_sel,
  output logic [NUM_REGS*8-1:0]   regs_flat
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]           regs_q  [NUM_REGS];
  logic [7:0]           wmask_a [NUM_REGS];

  logic [SEL_WIDTH-1:0] q_addr  [QDEPTH];
  logic [7:0]           q_data  [QDEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                 lp_status;

  logic                 access, addr_wr, data_wr, stat_rd, data_rd, data_acc;
  logic                 sel_exists, sel_ext;
  logic [IDX_W-1:0]     idx;
  logic [7:0]           sel_rd_val;
  logic [7:0]           status;
  logic                 q_empty, q_full, push, pop, lp_set;

  // Per-register masks and flat export of the register array
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign wmask_a[gi]             = WMASK[8*gi +: 8];
    assign regs_flat[8*gi +: 8]    = regs_q[gi];
  end

  // Access decode
  assign access   = bus.cs & bus.enable_bus;
  assign addr_wr  = access & ~bus.rs &  bus.we;
  assign stat_rd  = access & ~bus.rs & ~bus.we;
  assign data_wr  = access &  bus.rs &  bus.we;
  assign data_rd  = access &  bus.rs & ~bus.we;
  assign data_acc = access &  bus.rs;

  // Selected register: existence depends on chip version for the late registers
  assign sel_exists = (32'(reg_sel) < NUM_REGS) &&
                      ((32'(reg_sel) < VER_FIRST) || version[1]);
  assign idx        = sel_exists ? IDX_W'(reg_sel) : '0;
  assign sel_ext    = sel_exists & EXT_MASK[idx];

  always_comb begin
    sel_rd_val = 8'hFF;
    if (sel_exists) begin
      if (sel_ext) sel_rd_val = bus.ext_rdata;
      else         sel_rd_val = regs_q[idx] | ~wmask_a[idx];
    end
  end

  // Queue control; a full queue still accepts a push when the head pops
  assign q_empty = (count == '0);
  assign q_full  = (count == CNT_W'(QDEPTH));
  assign pop     = ~q_empty & bus.ext_wr_ready;
  assign push    = data_wr & sel_ext & (~q_full | pop);

  assign bus.ext_wr_valid = ~q_empty;
  assign bus.ext_wr_addr  = q_addr[rd_ptr];
  assign bus.ext_wr_data  = q_data[rd_ptr];

  assign status = {~(ram_busy | ~q_empty), lp_status, vblank, 3'b000, version};
  assign lp_set = lp_strobe & ~lp_status;

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only observed while count is non-zero
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= reg_sel;
      q_data[wr_ptr] <= bus.db_in;
    end
  end

  // Register array; light-pen latch takes priority over a CPU write to R16/R17
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (data_wr && sel_exists && !sel_ext && (idx == IDX_W'(i)))
          regs_q[i] <= (regs_q[i] & ~wmask_a[i]) | (bus.db_in & wmask_a[i]);
      end
      if (lp_set) begin
        regs_q[16] <= lp_v & wmask_a[16];
        regs_q[17] <= lp_h & wmask_a[17];
      end
    end
  end

  // Select latch, read data and light-pen status
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_sel    <= '0;
      bus.db_out <= 8'hFF;
      lp_status  <= 1'b0;
    end else begin
      if (addr_wr)
        reg_sel <= SEL_WIDTH'(bus.db_in);
      else if (AUTO_INC && data_acc)
        reg_sel <= (32'(reg_sel) == NUM_REGS - 1) ? '0 : reg_sel + 1'b1;

      if (stat_rd)      bus.db_out <= status;
      else if (data_rd) bus.db_out <= sel_rd_val;

      // A new strobe wins over a clearing status read on the same cycle
      if (lp_set)       lp_status <= 1'b1;
      else if (stat_rd) lp_status <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vdc_regfile_gen.sv
// Scoreboard bench for vdc_regfile_gen: reads and queue pops are checked by a
// monitor against expectations pushed by the stimulus process.
module tb_vdc_regfile_gen;

  localparam int unsigned NR = 38;
  localparam int unsigned SW = 6;
  localparam logic [NR*8-1:0] TB_WMASK = {{32{8'hFF}}, 8'h1F, {5{8'hFF}}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [1:0]    version;
  logic          vblank, ram_busy, lp_strobe;
  logic [7:0]    lp_v, lp_h;
  logic [SW-1:0] reg_sel0, reg_sel1;
  logic [NR*8-1:0] flat0, flat1;

  vdc_regfile_gen_if #(.SEL_WIDTH(SW)) bus0 ();
  vdc_regfile_gen_if #(.SEL_WIDTH(SW)) bus1 ();

  vdc_regfile_gen #(.WMASK(TB_WMASK), .AUTO_INC(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .version(version), .bus(bus0.slave),
    .vblank(vblank), .ram_busy(ram_busy), .lp_strobe(lp_strobe),
    .lp_v(lp_v), .lp_h(lp_h), .reg_sel(reg_sel0), .regs_flat(flat0)
  );

  vdc_regfile_gen #(.AUTO_INC(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .version(version), .bus(bus1.slave),
    .vblank(vblank), .ram_busy(ram_busy), .lp_strobe(lp_strobe),
    .lp_v(lp_v), .lp_h(lp_h), .reg_sel(reg_sel1), .regs_flat(flat1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  rd_exp_q [$];
  logic [13:0] ext_exp_q [$];
  logic        rd_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: db_out is due one cycle after a read strobe; queue pops on valid & ready
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_exp_q.size() == 0) check("db_out_unexpected", 32'(bus0.db_out), 32'hFFFF_FFFF);
      else                      check("db_out", 32'(bus0.db_out), 32'(rd_exp_q.pop_front()));
    end
    rd_pend = bus0.cs & bus0.enable_bus & ~bus0.we & ~reset;
    if (bus0.ext_wr_valid && bus0.ext_wr_ready && !reset) begin
      if (ext_exp_q.size() == 0) check("ext_pop_unexpected", 32'({bus0.ext_wr_addr, bus0.ext_wr_data}), 32'hFFFF_FFFF);
      else check("ext_pop", 32'({bus0.ext_wr_addr, bus0.ext_wr_data}), 32'(ext_exp_q.pop_front()));
    end
  end

  task automatic bus_op(input int d, input logic rs, input logic we, input logic [7:0] data);
    @(posedge clk); #1;
    if (d == 0) begin
      bus0.cs = 1'b1; bus0.enable_bus = 1'b1; bus0.rs = rs; bus0.we = we; bus0.db_in = data;
    end else begin
      bus1.cs = 1'b1; bus1.enable_bus = 1'b1; bus1.rs = rs; bus1.we = we; bus1.db_in = data;
    end
    @(posedge clk); #1;
    bus0.cs = 1'b0; bus0.enable_bus = 1'b0;
    bus1.cs = 1'b0; bus1.enable_bus = 1'b0;
  endtask

  task automatic sel(input int d, input logic [7:0] r);  bus_op(d, 1'b0, 1'b1, r); endtask
  task automatic wr(input int d, input logic [7:0] v);   bus_op(d, 1'b1, 1'b1, v); endtask
  task automatic rd_data(input logic [7:0] exp); rd_exp_q.push_back(exp); bus_op(0, 1'b1, 1'b0, 8'h00); endtask
  task automatic rd_stat(input logic [7:0] exp); rd_exp_q.push_back(exp); bus_op(0, 1'b0, 1'b0, 8'h00); endtask

  task automatic lp_pulse(input logic [7:0] v, input logic [7:0] h);
    @(posedge clk); #1;
    lp_v = v; lp_h = h; lp_strobe = 1'b1;
    @(posedge clk); #1;
    lp_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; version = 2'd2; vblank = 1'b1; ram_busy = 1'b0;
    lp_strobe = 1'b0; lp_v = 8'h00; lp_h = 8'h00;
    bus0.cs = 1'b0; bus0.enable_bus = 1'b0; bus0.rs = 1'b0; bus0.we = 1'b0;
    bus0.db_in = 8'h00; bus0.ext_rdata = 8'h5A; bus0.ext_wr_ready = 1'b0;
    bus1.cs = 1'b0; bus1.enable_bus = 1'b0; bus1.rs = 1'b0; bus1.we = 1'b0;
    bus1.db_in = 8'h00; bus1.ext_rdata = 8'h00; bus1.ext_wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_regs0_zero", 32'(flat0 != '0), 32'd0);
    check("rst_reg_sel", 32'(reg_sel0), 32'd0);
    check("rst_db_out", 32'(bus0.db_out), 32'hFF);
    check("rst_ext_valid", 32'(bus0.ext_wr_valid), 32'd0);

    // Status with version 2, vblank, idle
    rd_stat(8'hA2);

    // Write mask on R5
    sel(0, 8'd5); wr(0, 8'hFF);
    check("r5_masked_store", 32'(flat0[47:40]), 32'h1F);
    rd_data(8'hFF);
    wr(0, 8'h00);
    rd_data(8'hE0);

    // Version-gated R37
    version = 2'd0;
    sel(0, 8'd37); wr(0, 8'hC0);
    check("r37_v0_ignored", 32'(flat0[303:296]), 32'h00);
    rd_data(8'hFF);
    version = 2'd2;
    wr(0, 8'hC0);
    check("r37_v2_stored", 32'(flat0[303:296]), 32'hC0);
    rd_data(8'hC0);

    // External register queue, full-queue drop
    sel(0, 8'd31);
    rd_data(8'h5A);
    wr(0, 8'h11); ext_exp_q.push_back({6'd31, 8'h11});
    wr(0, 8'h22); ext_exp_q.push_back({6'd31, 8'h22});
    wr(0, 8'h33);
    check("ext_head_valid", 32'(bus0.ext_wr_valid), 32'd1);
    check("ext_head_held", 32'({bus0.ext_wr_addr, bus0.ext_wr_data}), 32'({6'd31, 8'h11}));
    rd_stat(8'h22);
    @(posedge clk); #1 bus0.ext_wr_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus0.ext_wr_ready = 1'b0;
    check("ext_drained", 32'(bus0.ext_wr_valid), 32'd0);
    rd_stat(8'hA2);

    // Light pen: first strobe latches, second ignored until status read
    lp_pulse(8'h40, 8'h21);
    lp_pulse(8'h55, 8'h66);
    check("lp_r16", 32'(flat0[135:128]), 32'h40);
    check("lp_r17", 32'(flat0[143:136]), 32'h21);
    rd_stat(8'hE2);
    rd_stat(8'hA2);
    sel(0, 8'd16); rd_data(8'h40); rd_data(8'h40);
    check("no_auto_inc", 32'(reg_sel0), 32'd16);
    sel(0, 8'd17); rd_data(8'h21);
    ram_busy = 1'b1;
    rd_stat(8'h22);
    ram_busy = 1'b0;

    // Auto-increment with wrap
    sel(1, 8'd36); wr(1, 8'hAB); wr(1, 8'hCD);
    check("ai_r36", 32'(flat1[295:288]), 32'hAB);
    check("ai_r37", 32'(flat1[303:296]), 32'hCD);
    check("ai_wrap", 32'(reg_sel1), 32'd0);

    // Reset with an entry pending in the queue
    sel(0, 8'd18); wr(0, 8'h77);
    check("q_valid_pre_rst", 32'(bus0.ext_wr_valid), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("rst_flush_valid", 32'(bus0.ext_wr_valid), 32'd0);
    check("rst_regs_cleared", 32'(flat0 != '0), 32'd0);
    check("rst_db_out2", 32'(bus0.db_out), 32'hFF);

    for (int i = 0; i < 20 && (rd_exp_q.size() != 0 || ext_exp_q.size() != 0); i++)
      @(posedge clk);
    check("scoreboard_drained", 32'(rd_exp_q.size() + ext_exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
